// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two cache miss ports, the arbiter and data_memory.
// The arbiter takes the slave view; caches and memory together take the master view.
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH  = 28,
    parameter int BLOCK_WIDTH = 128
);
    logic                   IC_READ;
    logic [ADDR_WIDTH-1:0]  IC_ADDRESS;
    logic [BLOCK_WIDTH-1:0] IC_READ_DATA;
    logic                   IC_BUSYWAIT;

    logic                   DC_READ;
    logic                   DC_WRITE;
    logic [ADDR_WIDTH-1:0]  DC_ADDRESS;
    logic [BLOCK_WIDTH-1:0] DC_WRITE_DATA;
    logic [BLOCK_WIDTH-1:0] DC_READ_DATA;
    logic                   DC_BUSYWAIT;

    logic                   MEM_READ;
    logic                   MEM_WRITE;
    logic [ADDR_WIDTH-1:0]  MEM_ADDRESS;
    logic [BLOCK_WIDTH-1:0] MEM_WRITE_DATA;
    logic [BLOCK_WIDTH-1:0] MEM_READ_DATA;
    logic                   MEM_BUSYWAIT;

    modport slave (
        input  IC_READ, IC_ADDRESS,
        input  DC_READ, DC_WRITE, DC_ADDRESS, DC_WRITE_DATA,
        input  MEM_READ_DATA, MEM_BUSYWAIT,
        output IC_READ_DATA, IC_BUSYWAIT,
        output DC_READ_DATA, DC_BUSYWAIT,
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA
    );

    modport master (
        output IC_READ, IC_ADDRESS,
        output DC_READ, DC_WRITE, DC_ADDRESS, DC_WRITE_DATA,
        output MEM_READ_DATA, MEM_BUSYWAIT,
        input  IC_READ_DATA, IC_BUSYWAIT,
        input  DC_READ_DATA, DC_BUSYWAIT,
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one block-wide data_memory between the
// instruction-cache miss port and the data-cache miss/write-back port.
module memory_arbiter #(
    parameter int ADDR_WIDTH  = 28,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic            CLK,
    input  logic            RESET,
    memory_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;
    typedef enum logic {PORT_IC, PORT_DC} port_t;

    state_t                 state, state_nx;
    port_t                  grant, last_grant, winner;
    logic                   ic_req, dc_req, any_req, win_wr;
    logic                   op_rd_p0, op_wr_p0;
    logic [ADDR_WIDTH-1:0]  addr_p0;
    logic [BLOCK_WIDTH-1:0] wdata_p0;
    logic [BLOCK_WIDTH-1:0] ic_data_p1, dc_data_p1;

    assign ic_req  = bus.IC_READ;
    assign dc_req  = bus.DC_READ | bus.DC_WRITE;
    assign any_req = ic_req | dc_req;

    // On a tie the port that was not served last wins.
    always_comb begin
        winner = PORT_IC;
        if (dc_req && (!ic_req || last_grant == PORT_IC))
            winner = PORT_DC;
    end

    // A simultaneous DC read+write is carried out as a write only.
    assign win_wr = (winner == PORT_DC) && bus.DC_WRITE;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        bus.MEM_READ    = 1'b0;
        bus.MEM_WRITE   = 1'b0;
        bus.IC_BUSYWAIT = ic_req;
        bus.DC_BUSYWAIT = dc_req;
        unique case (state)
            IDLE: begin
                if (any_req)
                    state_nx = ACCESS;
            end
            ACCESS: begin
                bus.MEM_READ  = op_rd_p0;
                bus.MEM_WRITE = op_wr_p0;
                if (!bus.MEM_BUSYWAIT)
                    state_nx = CAPTURE;
            end
            CAPTURE: begin
                state_nx = DONE;
            end
            DONE: begin
                if (grant == PORT_IC)
                    bus.IC_BUSYWAIT = 1'b0;
                else
                    bus.DC_BUSYWAIT = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // Request stage: winner's op, address and write block held for the transfer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            grant      <= PORT_IC;
            last_grant <= PORT_DC;
            op_rd_p0   <= 1'b0;
            op_wr_p0   <= 1'b0;
            addr_p0    <= '0;
            wdata_p0   <= '0;
        end else if (state == IDLE && any_req) begin
            grant      <= winner;
            last_grant <= winner;
            op_wr_p0   <= win_wr;
            op_rd_p0   <= !win_wr;
            addr_p0    <= (winner == PORT_DC) ? bus.DC_ADDRESS : bus.IC_ADDRESS;
            if (win_wr)
                wdata_p0 <= bus.DC_WRITE_DATA;
        end
    end

    // Return stage: completed read block steered to the granted port.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ic_data_p1 <= '0;
            dc_data_p1 <= '0;
        end else if (state == CAPTURE && op_rd_p0) begin
            if (grant == PORT_IC)
                ic_data_p1 <= bus.MEM_READ_DATA;
            else
                dc_data_p1 <= bus.MEM_READ_DATA;
        end
    end

    assign bus.MEM_ADDRESS    = addr_p0;
    assign bus.MEM_WRITE_DATA = wdata_p0;
    assign bus.IC_READ_DATA   = ic_data_p1;
    assign bus.DC_READ_DATA   = dc_data_p1;
endmodule
